// File: rtl/lpc_qchan_ctrl.sv
// lpc_qchan_ctrl: Q-channel quiescence controller for the low-power FIFO channel.
// Issues qreqn after an idle period, tracks accept/deny/timeout and reopens on wake.
module lpc_qchan_ctrl #(
    parameter int IDLE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             wake_req_i,
    input  logic             qactive_i,
    input  logic             qacceptn_i,
    input  logic             qdeny_i,
    output logic             qreqn_o,
    output logic             stopped_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             proto_err_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] sleep_cnt_o
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        REQ     = 3'd1,
        STOPPED = 3'd2,
        EXIT    = 3'd3,
        DENIED  = 3'd4
    } state_t;

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    logic [IW-1:0] r_idle;
    logic [TW-1:0] r_tmo;
    logic          r_qacc_d;
    logic          w_idle;
    logic          w_wake;
    logic          w_perr;

    assign w_idle = enable_i & ~wake_req_i & ~qactive_i & qacceptn_i & ~qdeny_i;
    assign w_wake = qactive_i | wake_req_i | ~enable_i;
    // Rising qacceptn in STOPPED means the channel withdrew its accept unprompted.
    assign w_perr = (~qacceptn_i & qdeny_i) | ((r_state == RUN) & ~qacceptn_i)
                  | ((r_state == STOPPED) & qacceptn_i & ~r_qacc_d);
    assign state_o = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_idle      <= '0;
            r_tmo       <= '0;
            r_qacc_d    <= 1'b1;
            qreqn_o     <= 1'b1;
            stopped_o   <= 1'b0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            proto_err_o <= 1'b0;
            sleep_cnt_o <= '0;
        end else begin
            r_qacc_d  <= qacceptn_i;
            timeout_o <= 1'b0;
            if (w_perr)
                proto_err_o <= 1'b1;
            case (r_state)
                RUN: begin
                    if (!w_idle)
                        r_idle <= '0;
                    else if (r_idle == IW'(IDLE_CYCLES - 1)) begin
                        r_idle  <= '0;
                        r_state <= REQ;
                        qreqn_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end else
                        r_idle <= r_idle + 1'b1;
                end
                REQ: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (!qacceptn_i) begin
                        r_state   <= STOPPED;
                        stopped_o <= 1'b1;
                        if (sleep_cnt_o != '1)
                            sleep_cnt_o <= sleep_cnt_o + 1'b1;
                    end else if (qdeny_i) begin
                        r_state <= DENIED;
                        qreqn_o <= 1'b1;
                    end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= EXIT;
                        qreqn_o   <= 1'b1;
                        timeout_o <= 1'b1;
                    end
                end
                STOPPED: begin
                    if (w_wake) begin
                        r_state   <= EXIT;
                        qreqn_o   <= 1'b1;
                        stopped_o <= 1'b0;
                    end
                end
                EXIT: begin
                    if (qacceptn_i) begin
                        r_state <= RUN;
                        busy_o  <= 1'b0;
                        r_idle  <= '0;
                        r_tmo   <= '0;
                    end
                end
                DENIED: begin
                    if (!qdeny_i && qacceptn_i) begin
                        r_state <= RUN;
                        busy_o  <= 1'b0;
                        r_idle  <= '0;
                        r_tmo   <= '0;
                    end
                end
                default: begin
                    r_state   <= RUN;
                    qreqn_o   <= 1'b1;
                    stopped_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lpc_qchan_ctrl.sv
// tb_lpc_qchan_ctrl: directed and randomized checks of lpc_qchan_ctrl against
// a cycle-level behavioural model plus literal expectations.
module tb_lpc_qchan_ctrl;
    localparam int IDLE = 4;
    localparam int TMO  = 8;
    localparam int CW   = 2;
    localparam int SAT  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b1, wk = 1'b0, qa = 1'b0, acc = 1'b1, dn = 1'b0;
    logic qreqn_o, stopped_o, busy_o, timeout_o, proto_err_o;
    logic [2:0] state_o;
    logic [CW-1:0] sleep_cnt_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lpc_qchan_ctrl #(.IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(en), .wake_req_i(wk),
        .qactive_i(qa), .qacceptn_i(acc), .qdeny_i(dn),
        .qreqn_o(qreqn_o), .stopped_o(stopped_o), .busy_o(busy_o),
        .timeout_o(timeout_o), .proto_err_o(proto_err_o),
        .state_o(state_o), .sleep_cnt_o(sleep_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: modes 0..4 follow the published state_o numbering.
    int   m_st, m_idle, m_age, m_sleeps;
    logic m_q, m_tmo, m_perr, m_pacc;

    task automatic model_reset();
        m_st = 0; m_idle = 0; m_age = 0; m_sleeps = 0;
        m_q = 1'b1; m_tmo = 1'b0; m_perr = 1'b0; m_pacc = 1'b1;
    endtask

    task automatic model_step();
        if ((!acc && dn) || (m_st == 0 && !acc) || (m_st == 2 && acc && !m_pacc))
            m_perr = 1'b1;
        m_pacc = acc;
        m_tmo = 1'b0;
        case (m_st)
            0: begin
                m_idle = (en && !wk && !qa && acc && !dn) ? m_idle + 1 : 0;
                if (m_idle == IDLE) begin
                    m_st = 1; m_q = 1'b0; m_idle = 0; m_age = 0;
                end
            end
            1: begin
                m_age++;
                if (!acc) begin
                    m_st = 2; m_sleeps++;
                end else if (dn) begin
                    m_st = 4; m_q = 1'b1;
                end else if (m_age == TMO) begin
                    m_st = 3; m_q = 1'b1; m_tmo = 1'b1;
                end
            end
            2: if (qa || wk || !en) begin m_st = 3; m_q = 1'b1; end
            3: if (acc) begin m_st = 0; m_idle = 0; end
            default: if (!dn && acc) begin m_st = 0; m_idle = 0; end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            #1;
            chk("qreqn", qreqn_o, m_q);
            chk("stopped", stopped_o, m_st == 2);
            chk("busy", busy_o, m_st != 0);
            chk("timeout", timeout_o, m_tmo);
            chk("proto_err", proto_err_o, m_perr);
            chk("state", state_o, m_st);
            chk("sleep_cnt", sleep_cnt_o, (m_sleeps > SAT) ? SAT : m_sleeps);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_in();
        en = 1'b1; wk = 1'b0; qa = 1'b0; dn = 1'b0;
    endtask

    task automatic enter_stop();
        idle_in();
        cyc(IDLE);
        cyc(2);
        acc = 1'b0;
        cyc(1);
        chk("enter_state", state_o, 2);
    endtask

    task automatic wake_by_wk();
        wk = 1'b1;
        cyc(1);
        wk = 1'b0; acc = 1'b1;
        cyc(1);
    endtask

    int   since, lat, mode;
    logic pq;

    initial begin
        cyc(2);
        chk("rst_qreqn", qreqn_o, 1);
        chk("rst_state", state_o, 0);
        reset_n = 1'b1;
        idle_in();
        cyc(2);
        qa = 1'b1;
        cyc(1);
        qa = 1'b0;
        cyc(3);
        chk("restart_qreqn_hi", qreqn_o, 1);
        cyc(1);
        chk("entry_qreqn_lo", qreqn_o, 0);
        chk("entry_state", state_o, 1);
        cyc(2);
        acc = 1'b0;
        cyc(1);
        chk("stop_state", state_o, 2);
        chk("stop_flag", stopped_o, 1);
        chk("stop_cnt", sleep_cnt_o, 1);
        qa = 1'b1;
        cyc(1);
        chk("wake_qa_qreqn", qreqn_o, 1);
        chk("wake_qa_state", state_o, 3);
        qa = 1'b0; acc = 1'b1;
        cyc(1);
        chk("wake_qa_run", state_o, 0);
        chk("wake_qa_stopped", stopped_o, 0);
        enter_stop();
        wk = 1'b1;
        cyc(1);
        chk("wake_wk_state", state_o, 3);
        wk = 1'b0; acc = 1'b1;
        cyc(1);
        chk("wake_wk_run", state_o, 0);
        enter_stop();
        en = 1'b0;
        cyc(1);
        chk("wake_en_state", state_o, 3);
        en = 1'b1; acc = 1'b1;
        cyc(1);
        chk("wake_en_run", state_o, 0);
        chk("cnt3", sleep_cnt_o, 3);
        enter_stop();
        chk("cnt_sat", sleep_cnt_o, 3);
        wake_by_wk();
        idle_in();
        cyc(IDLE + 1);
        dn = 1'b1;
        cyc(1);
        chk("deny_state", state_o, 4);
        chk("deny_qreqn", qreqn_o, 1);
        dn = 1'b0;
        cyc(1);
        chk("deny_run", state_o, 0);
        cyc(IDLE - 1);
        chk("deny_retry_hi", qreqn_o, 1);
        cyc(1);
        chk("deny_retry_lo", qreqn_o, 0);
        cyc(TMO - 1);
        chk("tmo_pre_state", state_o, 1);
        chk("tmo_pre_pulse", timeout_o, 0);
        cyc(1);
        chk("tmo_pulse", timeout_o, 1);
        chk("tmo_state", state_o, 3);
        chk("tmo_qreqn", qreqn_o, 1);
        cyc(1);
        chk("tmo_pulse_end", timeout_o, 0);
        chk("tmo_run", state_o, 0);
        cyc(IDLE);
        cyc(TMO - 1);
        acc = 1'b0;
        cyc(1);
        chk("late_acc_state", state_o, 2);
        chk("late_acc_nopulse", timeout_o, 0);
        wake_by_wk();
        idle_in();
        cyc(IDLE + 2);
        acc = 1'b0; dn = 1'b1;
        cyc(1);
        chk("perr_state", state_o, 2);
        chk("perr_flag", proto_err_o, 1);
        dn = 1'b0;
        wake_by_wk();
        chk("perr_sticky", proto_err_o, 1);
        chk("perr_run", state_o, 0);
        idle_in();
        cyc(IDLE + 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_qreqn", qreqn_o, 1);
        chk("async_state", state_o, 0);
        chk("async_stopped", stopped_o, 0);
        chk("async_cnt", sleep_cnt_o, 0);
        chk("async_perr", proto_err_o, 0);
        cyc(2);
        reset_n = 1'b1;
        pq = 1'b1; since = 0; lat = 1; mode = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                reset_n = 1'b0; acc = 1'b1; dn = 1'b0;
                cyc(2);
                reset_n = 1'b1;
            end
            if (qreqn_o !== pq) begin
                pq = qreqn_o;
                since = 0;
                lat = pq ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 10));
                mode = int'($urandom_range(0, 3));
            end else
                since++;
            if (!pq) begin
                if (since >= lat - 1) begin
                    if (mode < 2) acc = 1'b0;
                    else if (mode == 2) dn = 1'b1;
                end
            end else if (since >= lat - 1) begin
                acc = 1'b1; dn = 1'b0;
            end
            qa = ($urandom_range(0, 99) < 8);
            wk = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) >= 3);
        end
        cyc(1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
